vpq_delay_monitor: RTL and testbench

//  Per-input-port statistics engine, sits beside virtual_priority_queues (one instance per port).

---
 rtl/vpq_stats_pkg.sv | 29 ++
 rtl/vpq_prio_stat_lane.sv | 125 ++++++++++++
 rtl/vpq_delay_monitor.sv | 120 ++++++++++++
 tb/tb_vpq_delay_monitor.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/vpq_stats_pkg.sv
// Shared constants and helpers for the per-port VPQ delay statistics engine.
// Widths up to 64 bits are supported by the helpers below.
package vpq_stats_pkg;

    localparam logic [63:0] MIN_INIT = '1;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        return (res == 0) ? 1 : res;
    endfunction

    // Unsigned add of two zero-extended operands, clamped to all-ones of width w.
    function automatic logic [63:0] sat_add(
        input logic [63:0] a,
        input logic [63:0] b,
        input int          w
    );
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (65'd1 << w) - 65'd1;
        return (sum > lim) ? lim[63:0] : sum[63:0];
    endfunction

endpackage

// File: rtl/vpq_prio_stat_lane.sv
// One priority class: live counters, delay min/max/sum and snapshot copy.
// Strobes arriving here are already validated as belonging to this class.
module vpq_prio_stat_lane
    import vpq_stats_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int SUM_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr,
    input  logic                 rd,
    input  logic [WIDTH-1:0]     delay,
    input  logic                 snap,
    input  logic                 clear,
    output logic [WIDTH-1:0]     snap_cnt_in,
    output logic [WIDTH-1:0]     snap_cnt_out,
    output logic [WIDTH-1:0]     snap_min,
    output logic [WIDTH-1:0]     snap_max,
    output logic [SUM_WIDTH-1:0] snap_sum,
    output logic [WIDTH-1:0]     snap_backlog,
    output logic                 underflow
);

    localparam logic [WIDTH-1:0] MIN_RST = MIN_INIT[WIDTH-1:0];

    logic [WIDTH-1:0]     cnt_in;
    logic [WIDTH-1:0]     cnt_out;
    logic [WIDTH-1:0]     min_d;
    logic [WIDTH-1:0]     max_d;
    logic [SUM_WIDTH-1:0] sum_d;
    logic [WIDTH-1:0]     backlog;

    logic [WIDTH-1:0]     nxt_cnt_in;
    logic [WIDTH-1:0]     nxt_cnt_out;
    logic [WIDTH-1:0]     nxt_min;
    logic [WIDTH-1:0]     nxt_max;
    logic [SUM_WIDTH-1:0] nxt_sum;
    logic [WIDTH-1:0]     nxt_backlog;

    logic [63:0] inc_in;
    logic [63:0] inc_out;
    logic [63:0] inc_bl;
    logic [63:0] add_sum;

    assign underflow = rd && (backlog == '0);

    // Live state after applying this cycle's events.
    always_comb begin
        inc_in      = sat_add(64'(cnt_in), 64'd1, WIDTH);
        inc_out     = sat_add(64'(cnt_out), 64'd1, WIDTH);
        inc_bl      = sat_add(64'(backlog), 64'd1, WIDTH);
        add_sum     = sat_add(64'(sum_d), 64'(delay), SUM_WIDTH);
        nxt_cnt_in  = cnt_in;
        nxt_cnt_out = cnt_out;
        nxt_min     = min_d;
        nxt_max     = max_d;
        nxt_sum     = sum_d;
        nxt_backlog = backlog;
        if (wr) begin
            nxt_cnt_in = inc_in[WIDTH-1:0];
        end
        if (rd) begin
            nxt_cnt_out = inc_out[WIDTH-1:0];
            nxt_sum     = add_sum[SUM_WIDTH-1:0];
            if (delay < min_d) begin
                nxt_min = delay;
            end
            if (delay > max_d) begin
                nxt_max = delay;
            end
        end
        if (wr && !rd) begin
            nxt_backlog = inc_bl[WIDTH-1:0];
        end else if (rd && !wr && backlog != '0) begin
            nxt_backlog = backlog - 1'b1;
        end
    end

    // Live registers; a clearing snapshot restarts all but the backlog.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_in  <= '0;
            cnt_out <= '0;
            min_d   <= MIN_RST;
            max_d   <= '0;
            sum_d   <= '0;
            backlog <= '0;
        end else if (snap && clear) begin
            cnt_in  <= '0;
            cnt_out <= '0;
            min_d   <= MIN_RST;
            max_d   <= '0;
            sum_d   <= '0;
            backlog <= nxt_backlog;
        end else begin
            cnt_in  <= nxt_cnt_in;
            cnt_out <= nxt_cnt_out;
            min_d   <= nxt_min;
            max_d   <= nxt_max;
            sum_d   <= nxt_sum;
            backlog <= nxt_backlog;
        end
    end

    // Snapshot captures the live state including the snap cycle's events.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_cnt_in  <= '0;
            snap_cnt_out <= '0;
            snap_min     <= MIN_RST;
            snap_max     <= '0;
            snap_sum     <= '0;
            snap_backlog <= '0;
        end else if (snap) begin
            snap_cnt_in  <= nxt_cnt_in;
            snap_cnt_out <= nxt_cnt_out;
            snap_min     <= nxt_min;
            snap_max     <= nxt_max;
            snap_sum     <= nxt_sum;
            snap_backlog <= nxt_backlog;
        end
    end

endmodule

// File: rtl/vpq_delay_monitor.sv
// Per-port queueing statistics: one lane per priority class plus
// strobe validation, sticky error flag and snapshot readout mux.
module vpq_delay_monitor
    import vpq_stats_pkg::*;
#(
    parameter int PRIORITY  = 4,
    parameter int LOGP      = clog2(PRIORITY),
    parameter int WIDTH     = 32,
    parameter int SUM_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_wr,
    input  logic [PRIORITY-1:0]  i_wr_priority,
    input  logic                 i_rd,
    input  logic [PRIORITY-1:0]  i_rd_priority,
    input  logic [WIDTH-1:0]     i_data,
    input  logic [WIDTH-1:0]     i_now,
    input  logic                 i_snap,
    input  logic                 i_clear_on_snap,
    input  logic [LOGP-1:0]      i_rd_sel,
    output logic                 o_snap_valid,
    output logic [WIDTH-1:0]     o_cnt_in,
    output logic [WIDTH-1:0]     o_cnt_out,
    output logic [WIDTH-1:0]     o_min_delay,
    output logic [WIDTH-1:0]     o_max_delay,
    output logic [SUM_WIDTH-1:0] o_sum_delay,
    output logic [WIDTH-1:0]     o_backlog,
    output logic                 o_err
);

    logic [WIDTH-1:0] delay;
    logic             wr_ok;
    logic             rd_ok;
    logic             wr_bad;
    logic             rd_bad;
    logic             err_hit;

    logic [PRIORITY-1:0] lane_wr;
    logic [PRIORITY-1:0] lane_rd;
    logic [PRIORITY-1:0] lane_uf;

    logic [WIDTH-1:0]     s_cnt_in  [PRIORITY];
    logic [WIDTH-1:0]     s_cnt_out [PRIORITY];
    logic [WIDTH-1:0]     s_min     [PRIORITY];
    logic [WIDTH-1:0]     s_max     [PRIORITY];
    logic [SUM_WIDTH-1:0] s_sum     [PRIORITY];
    logic [WIDTH-1:0]     s_backlog [PRIORITY];

    logic [31:0] sel_ext;

    // Unsigned subtraction absorbs a wrap of the free-running clock.
    assign delay = i_now - i_data;

    assign wr_ok  = i_wr && $onehot(i_wr_priority);
    assign rd_ok  = i_rd && $onehot(i_rd_priority);
    assign wr_bad = i_wr && !$onehot(i_wr_priority);
    assign rd_bad = i_rd && !$onehot(i_rd_priority);

    assign lane_wr = wr_ok ? i_wr_priority : '0;
    assign lane_rd = rd_ok ? i_rd_priority : '0;

    assign err_hit = wr_bad || rd_bad || (|lane_uf);

    for (genvar k = 0; k < PRIORITY; k++) begin : g_lane
        vpq_prio_stat_lane #(
            .WIDTH     (WIDTH),
            .SUM_WIDTH (SUM_WIDTH)
        ) u_lane (
            .clk          (clk),
            .reset        (reset),
            .wr           (lane_wr[k]),
            .rd           (lane_rd[k]),
            .delay        (delay),
            .snap         (i_snap),
            .clear        (i_clear_on_snap),
            .snap_cnt_in  (s_cnt_in[k]),
            .snap_cnt_out (s_cnt_out[k]),
            .snap_min     (s_min[k]),
            .snap_max     (s_max[k]),
            .snap_sum     (s_sum[k]),
            .snap_backlog (s_backlog[k]),
            .underflow    (lane_uf[k])
        );
    end

    // Snapshot-done pulse and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_snap_valid <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_snap_valid <= i_snap;
            o_err        <= o_err || err_hit;
        end
    end

    assign sel_ext = 32'(i_rd_sel);

    // Readout mux; a selector past the last class reads zeros.
    always_comb begin
        o_cnt_in    = '0;
        o_cnt_out   = '0;
        o_min_delay = '0;
        o_max_delay = '0;
        o_sum_delay = '0;
        o_backlog   = '0;
        for (int k = 0; k < PRIORITY; k++) begin
            if (sel_ext == 32'(k)) begin
                o_cnt_in    = s_cnt_in[k];
                o_cnt_out   = s_cnt_out[k];
                o_min_delay = s_min[k];
                o_max_delay = s_max[k];
                o_sum_delay = s_sum[k];
                o_backlog   = s_backlog[k];
            end
        end
    end

endmodule

// File: tb/tb_vpq_delay_monitor.sv
// Directed bench for vpq_delay_monitor with hand-computed expectations.
// Inputs change #1 after a rising edge; outputs are read in that window.
module tb_vpq_delay_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_wr;
    logic [3:0]  i_wr_priority;
    logic        i_rd;
    logic [3:0]  i_rd_priority;
    logic [31:0] i_data;
    logic [31:0] i_now;
    logic        i_snap;
    logic        i_clear_on_snap;
    logic [1:0]  i_rd_sel;
    logic        o_snap_valid;
    logic [31:0] o_cnt_in;
    logic [31:0] o_cnt_out;
    logic [31:0] o_min_delay;
    logic [31:0] o_max_delay;
    logic [63:0] o_sum_delay;
    logic [31:0] o_backlog;
    logic        o_err;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    vpq_delay_monitor dut (
        .clk             (clk),
        .reset           (reset),
        .i_wr            (i_wr),
        .i_wr_priority   (i_wr_priority),
        .i_rd            (i_rd),
        .i_rd_priority   (i_rd_priority),
        .i_data          (i_data),
        .i_now           (i_now),
        .i_snap          (i_snap),
        .i_clear_on_snap (i_clear_on_snap),
        .i_rd_sel        (i_rd_sel),
        .o_snap_valid    (o_snap_valid),
        .o_cnt_in        (o_cnt_in),
        .o_cnt_out       (o_cnt_out),
        .o_min_delay     (o_min_delay),
        .o_max_delay     (o_max_delay),
        .o_sum_delay     (o_sum_delay),
        .o_backlog       (o_backlog),
        .o_err           (o_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of stimulus; all strobes drop afterwards.
    task automatic cyc(input logic wr, input logic [3:0] wp,
                       input logic rd, input logic [3:0] rp,
                       input logic [31:0] data, input logic [31:0] now,
                       input logic snap, input logic clr);
        i_wr            = wr;
        i_wr_priority   = wp;
        i_rd            = rd;
        i_rd_priority   = rp;
        i_data          = data;
        i_now           = now;
        i_snap          = snap;
        i_clear_on_snap = clr;
        tick();
        i_wr            = 1'b0;
        i_rd            = 1'b0;
        i_snap          = 1'b0;
        i_clear_on_snap = 1'b0;
        i_wr_priority   = '0;
        i_rd_priority   = '0;
    endtask

    task automatic wr_ev(input logic [3:0] p);
        cyc(1'b1, p, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic rd_ev(input logic [3:0] p, input logic [31:0] data,
                         input logic [31:0] now);
        cyc(1'b0, 4'd0, 1'b1, p, data, now, 1'b0, 1'b0);
    endtask

    task automatic do_snap(input string tag);
        cyc(1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        check({tag, "_valid"}, 64'(o_snap_valid), 64'd1);
        tick();
        check({tag, "_valid_low"}, 64'(o_snap_valid), 64'd0);
    endtask

    task automatic chk_cls(input string tag, input logic [1:0] sel,
                           input logic [31:0] cin, input logic [31:0] cout,
                           input logic [31:0] mn, input logic [31:0] mx,
                           input logic [63:0] sm, input logic [31:0] bl);
        i_rd_sel = sel;
        #1;
        check({tag, "_cnt_in"}, 64'(o_cnt_in), 64'(cin));
        check({tag, "_cnt_out"}, 64'(o_cnt_out), 64'(cout));
        check({tag, "_min"}, 64'(o_min_delay), 64'(mn));
        check({tag, "_max"}, 64'(o_max_delay), 64'(mx));
        check({tag, "_sum"}, o_sum_delay, sm);
        check({tag, "_backlog"}, 64'(o_backlog), 64'(bl));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset           = 1'b1;
        i_wr            = 1'b0;
        i_wr_priority   = '0;
        i_rd            = 1'b0;
        i_rd_priority   = '0;
        i_data          = '0;
        i_now           = '0;
        i_snap          = 1'b0;
        i_clear_on_snap = 1'b0;
        i_rd_sel        = '0;
        do_reset();

        // Reset state through an empty snapshot.
        repeat (10) tick();
        check("rst_valid", 64'(o_snap_valid), 64'd0);
        check("rst_err", 64'(o_err), 64'd0);
        chk_cls("rst_pre", 2'd0, 0, 0, ONES, 0, 0, 0);
        do_snap("snap0");
        for (int k = 0; k < 4; k++) begin
            chk_cls($sformatf("idle%0d", k), 2'(k), 0, 0, ONES, 0, 0, 0);
        end
        check("idle_err", 64'(o_err), 64'd0);

        // Class 1: three frames in, three out with delays 40, 8, 100.
        repeat (3) wr_ev(4'b0010);
        rd_ev(4'b0010, 32'd960, 32'd1000);
        rd_ev(4'b0010, 32'd1002, 32'd1010);
        rd_ev(4'b0010, 32'd1100, 32'd1200);
        do_snap("snap1");
        chk_cls("c1", 2'd1, 3, 3, 8, 100, 148, 0);
        chk_cls("c1_c0", 2'd0, 0, 0, ONES, 0, 0, 0);
        chk_cls("c1_c2", 2'd2, 0, 0, ONES, 0, 0, 0);
        check("c1_err", 64'(o_err), 64'd0);

        // Class 3: timestamp from before the clock wrapped.
        wr_ev(4'b1000);
        rd_ev(4'b1000, 32'hFFFF_FFF0, 32'h0000_0010);
        do_snap("snap2");
        chk_cls("wrap", 2'd3, 1, 1, 32'h20, 32'h20, 64'h20, 0);
        check("wrap_err", 64'(o_err), 64'd0);

        // Class 2: same-cycle enqueue and dequeue at backlog 1.
        wr_ev(4'b0100);
        cyc(1'b1, 4'b0100, 1'b1, 4'b0100, 32'd45, 32'd50, 1'b0, 1'b0);
        do_snap("snap3");
        chk_cls("wrrd", 2'd2, 2, 1, 5, 5, 5, 1);
        check("wrrd_err", 64'(o_err), 64'd0);

        // Drain class 2, then read once more on an empty class.
        rd_ev(4'b0100, 32'd50, 32'd60);
        check("drain_err", 64'(o_err), 64'd0);
        rd_ev(4'b0100, 32'd63, 32'd70);
        check("uflow_err", 64'(o_err), 64'd1);
        do_snap("snap4");
        chk_cls("uflow", 2'd2, 2, 3, 5, 10, 22, 0);

        // Multi-hot dequeue is dropped and flags a sticky error.
        do_reset();
        check("rst2_err", 64'(o_err), 64'd0);
        rd_ev(4'b0110, 32'd0, 32'd100);
        check("mhot_err", 64'(o_err), 64'd1);
        repeat (3) tick();
        check("mhot_sticky", 64'(o_err), 64'd1);
        do_snap("snap5");
        chk_cls("mhot_c1", 2'd1, 0, 0, ONES, 0, 0, 0);
        chk_cls("mhot_c2", 2'd2, 0, 0, ONES, 0, 0, 0);

        // Clearing snapshot keeps the backlog and the snap-cycle read.
        wr_ev(4'b0001);
        wr_ev(4'b0001);
        cyc(1'b0, 4'd0, 1'b1, 4'b0001, 32'd10, 32'd30, 1'b1, 1'b1);
        check("clr_valid", 64'(o_snap_valid), 64'd1);
        chk_cls("clr_snap", 2'd0, 2, 1, 20, 20, 20, 1);
        do_snap("snap6");
        chk_cls("clr_live", 2'd0, 0, 0, ONES, 0, 0, 1);

        // Reset mid-operation drops the strobe seen in the reset cycle.
        reset = 1'b1;
        cyc(1'b1, 4'b0001, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        reset = 1'b0;
        check("rst3_err", 64'(o_err), 64'd0);
        do_snap("snap7");
        chk_cls("rst3", 2'd0, 0, 0, ONES, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
